// File: rtl/btn_onehot_capture_pkg.sv
// Shared definitions for the push-button one-hot capture front end.
// Line count, press-vector type, default timing parameters and the one-hot picker.
package btn_onehot_capture_pkg;

  localparam int NUM_LINES           = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  typedef logic [NUM_LINES-1:0] onehot_t;

  // Two's-complement trick: x & -x isolates the lowest set bit.
  function automatic onehot_t lowestOneHot(input onehot_t x);
    return x & (~x + onehot_t'(1));
  endfunction

endpackage

// File: rtl/btn_onehot_capture_debounce_bit.sv
// One button line: multi-flop synchroniser, saturating-run debouncer and press detector.
// press_o is high on the edge where the debounced level rises.
module debounce_bit
  import btn_onehot_capture_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] syncChain_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;
  logic                   stable_q;
  logic                   stable_d;
  logic                   synced;

  assign synced = syncChain_q[SYNC_STAGES-1];

  // The counter measures how long the synced level has disagreed with the accepted level.
  always_comb begin
    count_d  = '0;
    stable_d = stable_q;
    if (synced != stable_q) begin
      if (count_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = synced;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      syncChain_q <= '0;
      count_q     <= '0;
      stable_q    <= 1'b0;
    end else begin
      syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], btn_i};
      count_q     <= count_d;
      stable_q    <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = stable_d & ~stable_q;

endmodule

// File: rtl/btn_onehot_capture.sv
// Debounced button presses queued as sticky pending bits and handed downstream
// one at a time as a strictly one-hot code with a valid/ready handshake.
module btn_onehot_capture
  import btn_onehot_capture_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] btn_in,
  output logic [NUM_LINES-1:0] onehot_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 overflow_out
);

  onehot_t press;
  onehot_t stableLevels_unused;
  onehot_t pending_q;
  onehot_t pending_d;
  onehot_t onehot_q;
  onehot_t onehot_d;
  onehot_t pick;
  onehot_t loadClear;
  logic    valid_q;
  logic    valid_d;
  logic    overflow_q;
  logic    overflow_d;
  logic    loadEn;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_in[i]),
      .stable_o(stableLevels_unused[i]),
      .press_o (press[i])
    );
  end

  // A press landing on the same edge its line is loaded re-arms the pending bit.
  always_comb begin
    loadEn     = !valid_q || ready_in;
    pick       = lowestOneHot(pending_q);
    loadClear  = loadEn ? pick : '0;
    pending_d  = (pending_q & ~loadClear) | press;
    overflow_d = |(press & pending_q & ~loadClear);
    onehot_d   = onehot_q;
    valid_d    = valid_q;
    if (loadEn) begin
      onehot_d = pick;
      valid_d  = |pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      onehot_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      onehot_q   <= onehot_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign onehot_out   = onehot_q;
  assign valid_out    = valid_q;
  assign overflow_out = overflow_q;

endmodule

// File: tb/tb_btn_onehot_capture.sv
// Scenario bench for btn_onehot_capture: expected codes are queued as presses are
// driven and popped by a monitor whenever a handshake completes.
module tb_btn_onehot_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = 4'b0000;
  logic [3:0] onehot_out;
  logic       valid_out;
  logic       ready_in = 1'b0;
  logic       overflow_out;

  int         checkCount = 0;
  int         errorCount = 0;
  int         overflowSeen = 0;
  logic [3:0] expQ[$];

  btn_onehot_capture dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .onehot_out  (onehot_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every accepted code must match the oldest outstanding press.
  always @(negedge clk) begin
    logic [3:0] expCode;
    if (!rst && valid_out && ready_in) begin
      checkCount++;
      if (expQ.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL handshake: got %b, required no output", onehot_out);
      end else begin
        expCode = expQ.pop_front();
        if (onehot_out !== expCode) begin
          errorCount++;
          $display("[TB] FAIL handshake: got %b, required %b", onehot_out, expCode);
        end
      end
    end
    if (!rst) begin
      checkCount++;
      if (!(onehot_out === 4'b0000 || $onehot(onehot_out)) || (valid_out === 1'b1 && onehot_out === 4'b0000)) begin
        errorCount++;
        $display("[TB] FAIL invariant: got onehot=%b valid=%b, required zero/one-hot and valid implies nonzero", onehot_out, valid_out);
      end
      if (overflow_out === 1'b1) overflowSeen++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required completion within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] btnVal, input logic readyVal);
    @(posedge clk);
    #1;
    btn_in   = btnVal;
    ready_in = readyVal;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitValid(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (valid_out === 1'b1) break;
    end
    checkCount++;
    if (k == budget) begin
      errorCount++;
      $display("[TB] FAIL %s: got valid_out=%b after %0d cycles, required 1", name, valid_out, budget);
    end
  endtask

  task automatic waitDrained(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (expQ.size() == 0 && valid_out === 1'b0) break;
    end
    checkCount++;
    if (k == budget) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d codes outstanding valid_out=%b, required 0 and 0", name, expQ.size(), valid_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleCycles(3);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checkCount++;
      if (onehot_out !== 4'b0000 || valid_out !== 1'b0 || overflow_out !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL reset_idle: got onehot=%b valid=%b ovf=%b, required 0000 0 0", onehot_out, valid_out, overflow_out);
      end
    end
  endtask

  task automatic test_single_press();
    applyStimulus(4'b0000, 1'b1);
    expQ.push_back(4'b0100);
    btn_in = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (valid_out !== (k == 6)) begin
        errorCount++;
        $display("[TB] FAIL single_latency: after edge %0d got valid=%b, required %b", k, valid_out, (k == 6));
      end
    end
    applyStimulus(4'b0000, 1'b1);
    repeat (12) begin
      @(negedge clk);
      checkCount++;
      if (valid_out !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL single_release: got valid=%b, required 0", valid_out);
      end
    end
  endtask

  task automatic test_glitch();
    applyStimulus(4'b0010, 1'b1);
    idleCycles(2);
    applyStimulus(4'b0000, 1'b1);
    repeat (15) begin
      @(negedge clk);
      checkCount++;
      if (valid_out !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL glitch_reject: got valid=%b, required 0", valid_out);
      end
    end
    expQ.push_back(4'b0010);
    applyStimulus(4'b0010, 1'b1);
    idleCycles(3);
    applyStimulus(4'b0000, 1'b1);
    waitDrained("glitch_accept", 20);
    idleCycles(10);
  endtask

  task automatic test_multi_backpressure();
    expQ.push_back(4'b0001);
    expQ.push_back(4'b0010);
    expQ.push_back(4'b1000);
    applyStimulus(4'b1011, 1'b0);
    waitValid("multi_valid", 20);
    repeat (5) begin
      @(negedge clk);
      checkCount++;
      if (onehot_out !== 4'b0001 || valid_out !== 1'b1) begin
        errorCount++;
        $display("[TB] FAIL multi_hold: got onehot=%b valid=%b, required 0001 1", onehot_out, valid_out);
      end
    end
    applyStimulus(4'b1011, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkCount++;
      if (valid_out !== (k < 3)) begin
        errorCount++;
        $display("[TB] FAIL multi_burst: cycle %0d got valid=%b, required %b", k, valid_out, (k < 3));
      end
    end
    applyStimulus(4'b0000, 1'b1);
    idleCycles(10);
  endtask

  task automatic test_overflow();
    int ovBase;
    expQ.push_back(4'b1000);
    applyStimulus(4'b1000, 1'b0);
    waitValid("overflow_hold_valid", 20);
    expQ.push_back(4'b0001);
    applyStimulus(4'b1001, 1'b0);
    idleCycles(10);
    applyStimulus(4'b1000, 1'b0);
    idleCycles(8);
    ovBase = overflowSeen;
    applyStimulus(4'b1001, 1'b0);
    idleCycles(12);
    checkCount++;
    if (overflowSeen - ovBase != 1) begin
      errorCount++;
      $display("[TB] FAIL overflow_pulse: got %0d overflow cycles, required 1", overflowSeen - ovBase);
    end
    checkCount++;
    if (onehot_out !== 4'b1000 || valid_out !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL overflow_hold: got onehot=%b valid=%b, required 1000 1", onehot_out, valid_out);
    end
    applyStimulus(4'b1001, 1'b1);
    waitDrained("overflow_drain", 10);
    applyStimulus(4'b0000, 1'b1);
    idleCycles(10);
  endtask

  task automatic test_reset_mid();
    expQ.push_back(4'b0001);
    expQ.push_back(4'b0010);
    expQ.push_back(4'b0100);
    applyStimulus(4'b0111, 1'b0);
    waitValid("resetmid_valid", 20);
    applyStimulus(4'b0000, 1'b0);
    idleCycles(10);
    checkCount++;
    if (onehot_out !== 4'b0001 || valid_out !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL resetmid_before: got onehot=%b valid=%b, required 0001 1", onehot_out, valid_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if (onehot_out !== 4'b0000 || valid_out !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL resetmid_after: got onehot=%b valid=%b, required 0000 0", onehot_out, valid_out);
    end
    applyStimulus(4'b0000, 1'b1);
    repeat (20) begin
      @(negedge clk);
      checkCount++;
      if (valid_out !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL resetmid_quiet: got valid=%b, required 0", valid_out);
      end
    end
  endtask

  initial begin
    $display("[TB] starting btn_onehot_capture scenarios");
    test_reset();
    test_single_press();
    test_glitch();
    test_multi_backpressure();
    test_overflow();
    test_reset_mid();
    checkCount++;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard_empty: got %0d outstanding codes, required 0", expQ.size());
    end
    checkCount++;
    if (overflowSeen != 1) begin
      errorCount++;
      $display("[TB] FAIL overflow_total: got %0d overflow cycles, required 1", overflowSeen);
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/btn_onehot_capture.md
Name: btn_onehot_capture

Overview:
- Upstream front end for the 4-to-2 encoder.
- Synchronises and debounces four raw push-button lines, then detects press (rising) edges.
- Queues presses as sticky pending bits and presents exactly one press at a time as a strictly one-hot 4-bit word with a valid/ready handshake.
- The downstream encoder therefore never sees zero-hot or multi-hot codes.

Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser chain (minimum 2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised level must differ from the debounced level before it is accepted (minimum 2).

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- btn_in  input  4  raw asynchronous button levels, bit i = line i
- onehot_out  output  4  one-hot press code; bit i set = line i pressed
- valid_out  output  1  onehot_out holds a press not yet accepted
- ready_in  input  1  downstream accepts onehot_out when valid_out & ready_in
- overflow_out  output  1  one-cycle pulse: a press arrived on a line whose earlier press is still pending

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high. While rst=1 at a clk edge, all registers clear: synchronisers, debounced levels, counters, pending, onehot_out=0, valid_out=0, overflow_out=0. Reset mid-handshake drops the held and pending presses with no further output.
- Synchroniser: per line, a SYNC_STAGES-flop chain; debounce acts only on the last stage.
- Debounce, per line:
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - If synced == stable, the counter clears.
  - Otherwise the counter increments. At the edge where it equals DEBOUNCE_CYCLES-1, stable takes the synced value and the counter clears.
  - Any mismatch run shorter than DEBOUNCE_CYCLES cycles is ignored.
- Press edge: press[i] = stable[i] rising at this edge (stable_next & ~stable). A release generates nothing.
- Pending: per line, a sticky bit.
  - Set on press[i].
  - Cleared when line i is loaded into the output register.
  - If set and clear happen on the same edge, set wins.
  - overflow_out=1 for one cycle when press[i] occurs while pending[i] is already 1 and is not being cleared on that edge. The extra press is dropped.
- Output register:
  - Loads when valid_out=0 or (valid_out & ready_in).
  - On load: if pending is non-zero, onehot_out is the lowest-index pending bit as one-hot, valid_out=1, and that pending bit clears. If pending is zero, onehot_out=0 and valid_out=0.
  - While valid_out & !ready_in, onehot_out and valid_out hold stable.
  - Back-to-back acceptance gives one press per cycle.
- Invariants: onehot_out is zero or exactly one-hot at all times. valid_out=1 implies onehot_out is non-zero.
- Latency: edge 0 is the first edge sampling a new btn_in level held steady. stable/pending update at edge SYNC_STAGES+DEBOUNCE_CYCLES-1, and valid_out rises after edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults, that is 6 edges.
- Simultaneous presses on several lines are all queued. They are presented in ascending index order, one per accepted handshake.

Decomposition:
- Shared package:
  - NUM_LINES=4 and the onehot vector typedef (logic [NUM_LINES-1:0]).
  - Default parameter constants.
  - A function returning the lowest set bit as one-hot (x & -x).
- Sub-module debounce_bit: synchroniser plus counter plus stable level for one line. It outputs stable and the press pulse and is instantiated NUM_LINES times. Pending bits, output register and overflow stay in the top.

Test Plan:
- Reset/idle: rst for 3 cycles, btn_in=0000 -> onehot_out=0000, valid_out=0, overflow_out=0 for 20 cycles.
- Single press, ready_in=1: btn_in 0000->0100 held 10 cycles -> valid_out=1 with onehot_out=0100 after edge 6 for exactly 1 cycle, then 0000/0. Release generates nothing.
- Glitch rejection: btn_in[1] high for 3 cycles then low -> valid_out stays 0. The same pulse held 4 cycles -> one 0010 output.
- Multi-press ordering with backpressure: btn_in 0000->1011 simultaneously, ready_in=0 -> onehot_out=0001 holds. Then ready_in=1 -> 0001, 0010, 1000 on consecutive cycles, then valid_out=0.
- Overflow: ready_in=0, press line 0, release for 6 cycles, press again -> overflow_out pulses 1 cycle when the second press is debounced. After ready_in=1, exactly one 0001 is delivered.
- Reset mid-operation: pending 0110 with valid_out=1, assert rst 1 cycle -> next cycle onehot_out=0000, valid_out=0, and no presses emerge afterwards with btn_in held steady.
